// File: rtl/controlador_entrada_saida.sv
// Sequences IN/OUT instructions against the enter pushbutton, the switches and the display register.
// Optional macro CONTROLADOR_OUT_PAUSA_EN: OUT also waits for an enter press before completing.
module controlador_entrada_saida #(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int LARGURA_CONT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enter,
    input  logic [8:0]  entradaSwitch,
    input  logic        pedidoEntrada,
    input  logic        pedidoSaida,
    input  logic [31:0] dadoSaida,
    output logic        pararPC,
    output logic        escritaBanco,
    output logic [31:0] dadoEntrada,
    output logic [31:0] dadoDisplay,
    output logic        displayValido,
    output logic        esperandoEntrada
);

    localparam logic [1:0] OCIOSO        = 2'd0;
    localparam logic [1:0] ESPERA_SOLTO  = 2'd1;
    localparam logic [1:0] ESPERA_APERTO = 2'd2;
    localparam logic [1:0] CONCLUI       = 2'd3;

    localparam logic [LARGURA_CONT-1:0] LIMITE = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

    logic                    enterSync1, enterSync2;
    logic                    apertado;
    logic [1:0]              estado, proxEstado;
    logic                    tipoEntrada;
    logic [LARGURA_CONT-1:0] contador, proxContador;
    logic                    pedido;
    logic                    nivelAlvo;

    // Two-flop synchronizer; resets to "released" so a reset never fakes a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enterSync1 <= 1'b1;
            enterSync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking so sync2 takes the old sync1, forming a real two-stage chain.
            enterSync1 <= enter;
            enterSync2 <= enterSync1;
        end
    end

    assign apertado  = !enterSync2;
    assign pedido    = pedidoEntrada | pedidoSaida;
    assign nivelAlvo = (estado == ESPERA_APERTO);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        proxEstado   = estado;
        proxContador = '0;
        case (estado)
            OCIOSO: begin
                if (pedidoEntrada) begin
                    proxEstado = ESPERA_SOLTO;
                end else if (pedidoSaida) begin
`ifdef CONTROLADOR_OUT_PAUSA_EN
                    proxEstado = ESPERA_SOLTO;
`else
                    proxEstado = CONCLUI;
`endif
                end
            end
            ESPERA_SOLTO, ESPERA_APERTO: begin
                if (!pedido) begin
                    proxEstado = OCIOSO;
                end else if (apertado == nivelAlvo) begin
                    if (contador == LIMITE)
                        proxEstado = (estado == ESPERA_SOLTO) ? ESPERA_APERTO : CONCLUI;
                    else
                        proxContador = contador + LARGURA_CONT'(1);
                end
            end
            CONCLUI: proxEstado = OCIOSO;
            default: proxEstado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            contador      <= '0;
            tipoEntrada   <= 1'b0;
            dadoEntrada   <= '0;
            dadoDisplay   <= '0;
            displayValido <= 1'b0;
        end else begin
            estado   <= proxEstado;
            contador <= proxContador;
            if (estado == OCIOSO && proxEstado != OCIOSO)
                tipoEntrada <= pedidoEntrada;
            if (estado == ESPERA_APERTO && proxEstado == CONCLUI && tipoEntrada)
                dadoEntrada <= {{23{entradaSwitch[8]}}, entradaSwitch};
            if (estado == CONCLUI && !tipoEntrada) begin
                dadoDisplay   <= dadoSaida;
                displayValido <= 1'b1;
            end
        end
    end

    // Releasing the PC in CONCLUI lets the PC and the register write advance on the same edge.
    assign pararPC          = pedido && (estado != CONCLUI) && !reset;
    assign escritaBanco     = (estado == CONCLUI) && tipoEntrada;
    assign esperandoEntrada = (estado == ESPERA_SOLTO) || (estado == ESPERA_APERTO);

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Randomized bench for controlador_entrada_saida; expected timing derived from enter sample windows.
`timescale 1ns/1ps
module tb_controlador_entrada_saida;

    localparam int D   = 4;
    localparam int LIM = 300;
`ifdef CONTROLADOR_OUT_PAUSA_EN
    localparam bit PAUSA = 1'b1;
`else
    localparam bit PAUSA = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, enter, pedidoEntrada, pedidoSaida;
    logic [8:0]  entradaSwitch;
    logic [31:0] dadoSaida;
    logic        pararPC, escritaBanco, displayValido, esperandoEntrada;
    logic [31:0] dadoEntrada, dadoDisplay;

    always #5 clock = ~clock;

    controlador_entrada_saida #(.DEBOUNCE_CICLOS(D), .LARGURA_CONT(8)) dut (
        .clock(clock), .reset(reset), .enter(enter), .entradaSwitch(entradaSwitch),
        .pedidoEntrada(pedidoEntrada), .pedidoSaida(pedidoSaida), .dadoSaida(dadoSaida),
        .pararPC(pararPC), .escritaBanco(escritaBanco), .dadoEntrada(dadoEntrada),
        .dadoDisplay(dadoDisplay), .displayValido(displayValido),
        .esperandoEntrada(esperandoEntrada)
    );

    int          vetores = 0;
    int          erros   = 0;
    bit          pat[64];
    int          patLen;
    bit          curEnter;
    logic [31:0] expEntrada, expDisplay;
    logic        expValido;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic addSeg(input bit v, input int n);
        for (int i = 0; i < n; i++)
            if (patLen < 64) begin
                pat[patLen] = v;
                patLen++;
            end
    endtask

    function automatic logic [31:0] sext(input logic [8:0] s);
        int v;
        v = int'(s);
        if (v > 255) v = v - 512;
        return 32'(v);
    endfunction

    // Raw enter level that the debouncer sees in cycle c (two-cycle synchronizer lag).
    function automatic bit amostra(input bit h1, input int c);
        int idx;
        if (c < 2) return h1;
        idx = c - 2;
        if (idx >= patLen) idx = patLen - 1;
        return pat[idx];
    endfunction

    function automatic bit janela(input bit h1, input int ult, input bit val);
        for (int c = ult - D + 1; c <= ult; c++)
            if (amostra(h1, c) != val) return 1'b0;
        return 1'b1;
    endfunction

    // Last waiting cycle: first D-long released window, then first D-long pressed window after it.
    function automatic int prever(input bit h1);
        int solto;
        solto = -1;
        for (int c = D; c < LIM; c++)
            if (janela(h1, c, 1'b1)) begin
                solto = c;
                break;
            end
        if (solto < 0) return -1;
        for (int c = solto + D; c < LIM; c++)
            if (janela(h1, c, 1'b0)) return c;
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pedidoEntrada = 1'b0;
            pedidoSaida   = 1'b0;
            enter         = curEnter;
            @(negedge clock);
            verifica("idle pararPC", 32'(pararPC), 32'(0));
            verifica("idle escritaBanco", 32'(escritaBanco), 32'(0));
            verifica("idle esperandoEntrada", 32'(esperandoEntrada), 32'(0));
            verifica("idle dadoEntrada", dadoEntrada, expEntrada);
            verifica("idle dadoDisplay", dadoDisplay, expDisplay);
            verifica("idle displayValido", 32'(displayValido), 32'(expValido));
            @(posedge clock); #1;
        end
    endtask

    // corte >= 0 stops after cycle corte-1 with the request still pending.
    task automatic runOp(input bit isIn, input bit ambos, input logic [8:0] sw,
                         input logic [31:0] ds, input int corte);
        int fim, ultimo;
        fim = (isIn || PAUSA) ? prever(curEnter) : 0;
        if (fim < 0) begin
            vetores++;
            erros++;
            $display("FAIL model bound: no completion within %0d cycles", LIM);
            return;
        end
        ultimo = (corte >= 0) ? corte - 1 : fim + 1;
        for (int c = 0; c <= ultimo; c++) begin
            pedidoEntrada = isIn;
            pedidoSaida   = !isIn || ambos;
            entradaSwitch = sw;
            dadoSaida     = ds;
            enter         = pat[(c < patLen) ? c : patLen - 1];
            curEnter      = enter;
            if (c == fim + 1 && isIn) expEntrada = sext(sw);
            @(negedge clock);
            verifica("op pararPC", 32'(pararPC), 32'(c <= fim));
            verifica("op escritaBanco", 32'(escritaBanco), 32'(c == fim + 1 && isIn));
            verifica("op esperandoEntrada", 32'(esperandoEntrada), 32'(c >= 1 && c <= fim));
            verifica("op dadoEntrada", dadoEntrada, expEntrada);
            verifica("op dadoDisplay", dadoDisplay, expDisplay);
            @(posedge clock); #1;
        end
        if (corte >= 0) return;
        if (!isIn) begin
            expDisplay = ds;
            expValido  = 1'b1;
        end
        pedidoEntrada = 1'b0;
        pedidoSaida   = 1'b0;
        @(negedge clock);
        verifica("post dadoEntrada", dadoEntrada, expEntrada);
        verifica("post dadoDisplay", dadoDisplay, expDisplay);
        verifica("post displayValido", 32'(displayValido), 32'(expValido));
        verifica("post pararPC", 32'(pararPC), 32'(0));
        verifica("post escritaBanco", 32'(escritaBanco), 32'(0));
        @(posedge clock); #1;
    endtask

    task automatic padraoAleatorio();
        patLen = 0;
        repeat ($urandom_range(0, 4)) addSeg(1'($urandom_range(0, 1)), $urandom_range(1, 6));
        addSeg(1'b1, D + $urandom_range(0, 2));
        addSeg(1'b0, D + 2 + $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) addSeg(1'b1, 1);
    endtask

    initial begin
        int fimR;
        reset = 1'b1; enter = 1'b1; curEnter = 1'b1;
        pedidoEntrada = 1'b0; pedidoSaida = 1'b0;
        entradaSwitch = '0; dadoSaida = '0;
        expEntrada = '0; expDisplay = '0; expValido = 1'b0;
        #2;
        verifica("reset pararPC", 32'(pararPC), 32'(0));
        verifica("reset escritaBanco", 32'(escritaBanco), 32'(0));
        verifica("reset esperandoEntrada", 32'(esperandoEntrada), 32'(0));
        verifica("reset dadoEntrada", dadoEntrada, 32'h0);
        verifica("reset dadoDisplay", dadoDisplay, 32'h0);
        verifica("reset displayValido", 32'(displayValido), 32'(0));
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        idle(3);

        // Basic IN with enter released, then held 8 cycles.
        patLen = 0; addSeg(1'b1, 6); addSeg(1'b0, 8);
        runOp(1'b1, 1'b0, 9'h005, 32'h0, -1);
        // Sign extension extremes; the second starts with enter still held.
        patLen = 0; addSeg(1'b1, 5); addSeg(1'b0, 6);
        runOp(1'b1, 1'b0, 9'h1FF, 32'h0, -1);
        runOp(1'b1, 1'b0, 9'h100, 32'h0, -1);
        // Bouncing press.
        patLen = 0; addSeg(1'b1, 5); addSeg(1'b0, 2); addSeg(1'b1, 1); addSeg(1'b0, 3);
        addSeg(1'b1, 1); addSeg(1'b0, 6);
        runOp(1'b1, 1'b0, 9'h0C3, 32'h0, -1);
        // Press held over from the previous IN.
        patLen = 0; addSeg(1'b0, 5); addSeg(1'b1, 4); addSeg(1'b0, 6);
        runOp(1'b1, 1'b0, 9'h07E, 32'h0, -1);
        idle(2);
        // OUT.
        patLen = 0; addSeg(1'b1, 5); addSeg(1'b0, 6);
        runOp(1'b0, 1'b0, 9'h0, 32'd123, -1);
        idle(1);

        // Request withdrawn while waiting.
        patLen = 0; addSeg(1'b1, 10); addSeg(1'b0, 10);
        runOp(1'b1, 1'b0, 9'h0AA, 32'h0, 3);
        pedidoEntrada = 1'b0; pedidoSaida = 1'b0;
        @(negedge clock);
        verifica("withdraw pararPC", 32'(pararPC), 32'(0));
        verifica("withdraw esperandoEntrada", 32'(esperandoEntrada), 32'(1));
        verifica("withdraw escritaBanco", 32'(escritaBanco), 32'(0));
        @(posedge clock); #1;
        idle(2);

        // Reset while in ESPERA_APERTO with enter pressed.
        patLen = 0; addSeg(1'b1, 5); addSeg(1'b0, 20);
        fimR = prever(curEnter);
        runOp(1'b1, 1'b0, 9'h033, 32'h0, fimR - 1);
        #2 reset = 1'b1;
        #1;
        verifica("midreset pararPC", 32'(pararPC), 32'(0));
        verifica("midreset escritaBanco", 32'(escritaBanco), 32'(0));
        verifica("midreset esperandoEntrada", 32'(esperandoEntrada), 32'(0));
        verifica("midreset dadoEntrada", dadoEntrada, 32'h0);
        verifica("midreset dadoDisplay", dadoDisplay, 32'h0);
        verifica("midreset displayValido", 32'(displayValido), 32'(0));
        expEntrada = '0; expDisplay = '0; expValido = 1'b0;
        pedidoEntrada = 1'b0; pedidoSaida = 1'b0; enter = 1'b1; curEnter = 1'b1;
        repeat (2) begin
            @(negedge clock);
            verifica("inreset escritaBanco", 32'(escritaBanco), 32'(0));
            @(posedge clock);
        end
        #1 reset = 1'b0;
        idle(3);
        // Both requests high: IN wins.
        patLen = 0; addSeg(1'b1, 5); addSeg(1'b0, 6);
        runOp(1'b1, 1'b1, 9'h07F, 32'd77, -1);
        idle(1);

        for (int t = 0; t < 30; t++) begin
            padraoAleatorio();
            runOp(($urandom_range(0, 9) < 7), 1'b0, 9'($urandom()), $urandom(), -1);
            idle($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
